// File: rtl/multicycle_controller_if.sv
//==============================================================================
// Module      : multicycle_controller_if
// Description : Bundles the instruction fields, datapath status and control
//               outputs exchanged between the multicycle datapath and its
//               controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface multicycle_controller_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic        illegal;
    logic [31:0] instret;

    // Datapath side: supplies instruction/status, consumes controls.
    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instret
    );

    // Controller side.
    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instret
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
//==============================================================================
// Module      : multicycle_controller
// Description : Multicycle RISC-V subset controller (lw, sw, R-type, I-type
//               ALU, jal, beq) with illegal-opcode trap and retired-instruction
//               counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_controller (
    input  wire logic             clk,
    input  wire logic             reset,
    multicycle_controller_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OP_STORE = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_out_state;
    logic [31:0] r_instret;
    logic        w_retire;
    logic [2:0]  w_funct_alu;

    logic        w_pc_write;
    logic        w_adr_src;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [2:0]  w_alu_control;
    logic [1:0]  w_imm_src;
    logic        w_illegal;

    // State register; reset always returns to FETCH, even mid-access.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)         r_instret <= 32'd0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

    // ALU operation for R/I-type execute; subtraction only exists for R-type.
    always_comb begin
        w_funct_alu = C_ALU_ADD;
        case (bus.funct3)
            3'b000:  w_funct_alu = (bus.op[5] & bus.funct7b5) ? C_ALU_SUB : C_ALU_ADD;
            3'b010:  w_funct_alu = C_ALU_SLT;
            3'b110:  w_funct_alu = C_ALU_OR;
            3'b111:  w_funct_alu = C_ALU_AND;
            default: w_funct_alu = C_ALU_ADD;
        endcase
    end

    // Immediate format is a pure opcode decode, independent of state.
    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            C_OP_STORE: w_imm_src = 2'b01;
            C_OP_BEQ:   w_imm_src = 2'b10;
            C_OP_JAL:   w_imm_src = 2'b11;
            default:    w_imm_src = 2'b00;
        endcase
    end

    // Next-state and output decode; reset shows FETCH decode with enables off.
    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = C_ALU_ADD;
        w_illegal     = 1'b0;
        w_out_state   = reset ? S_FETCH : r_state;

        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    C_OP_LOAD, C_OP_STORE: w_next_state = S_MEMADR;
                    C_OP_RTYPE:            w_next_state = S_EXECR;
                    C_OP_ITYPE:            w_next_state = S_EXECI;
                    C_OP_JAL:              w_next_state = S_JAL;
                    C_OP_BEQ:              w_next_state = S_BEQ;
                    default:               w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next_state = (bus.op == C_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    begin w_next_state = S_FETCH; w_retire = 1'b1; end
            S_MEMWRITE: if (bus.mem_ready) begin w_next_state = S_FETCH; w_retire = 1'b1; end
            S_EXECR,
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    begin w_next_state = S_FETCH; w_retire = 1'b1; end
            S_JAL:      w_next_state = S_ALUWB;
            S_BEQ:      begin w_next_state = S_FETCH; w_retire = 1'b1; end
            default:    w_next_state = S_ILLEGAL;
        endcase

        case (w_out_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD:  w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_funct_alu;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_funct_alu;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = C_ALU_SUB;
                w_pc_write    = bus.zero;
            end
            default:    w_illegal = 1'b1;
        endcase

        if (reset) begin
            w_pc_write  = 1'b0;
            w_ir_write  = 1'b0;
            w_reg_write = 1'b0;
            w_mem_write = 1'b0;
        end
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.MemWrite   = w_mem_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.RegWrite   = w_reg_write;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.illegal    = w_illegal;
    assign bus.instret    = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//==============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller: directed
//               scenarios plus randomized instruction streams compared against
//               a per-instruction-class expectation model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b101;

    localparam int LW = 0, SW = 1, RT = 2, IT = 3, JL = 4, BQ = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [31:0] m_instret;

    multicycle_controller_if ifc ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {ifc.PCWrite, ifc.AdrSrc, ifc.MemWrite, ifc.IRWrite, ifc.RegWrite,
                ifc.ResultSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUControl, ifc.ImmSrc,
                ifc.illegal};
    endfunction

    // Meaning of the funct fields: what arithmetic an R/I instruction asks for.
    function automatic logic [2:0] exp_alu(input bit is_r, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (is_r && f7) ? SUB : ADD;
        if (f3 == 3'b010) return SLT;
        if (f3 == 3'b110) return OR;
        if (f3 == 3'b111) return AND;
        return ADD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive mem_ready, check outputs mid-cycle, then take the edge.
    task automatic cyc(input logic mr, input logic [16:0] exp, input string tag, input bit retire);
        ifc.mem_ready = mr;
        @(negedge clk);
        chk(tag, {15'd0, observed()}, {15'd0, exp});
        chk({tag, "_instret"}, ifc.instret, m_instret);
        @(posedge clk);
        #1;
        if (retire) m_instret = m_instret + 32'd1;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic do_fetch(input logic [1:0] imm, input int fst);
        for (int i = 0; i < fst; i++)
            cyc(1'b0, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,imm,0), "fetch_wait", 0);
        cyc(1'b1, v(1,0,0,1,0,2'b10,2'b00,2'b10,ADD,imm,0), "fetch", 0);
        cyc(rbit(), v(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,imm,0), "decode", 0);
    endtask

    task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                             input logic z, input int fst, input int mst);
        logic [1:0] imm;
        ifc.funct3   = f3;
        ifc.funct7b5 = f7;
        ifc.zero     = z;
        case (cls)
            LW: begin ifc.op = 7'b0000011; imm = 2'b00; end
            SW: begin ifc.op = 7'b0100011; imm = 2'b01; end
            RT: begin ifc.op = 7'b0110011; imm = 2'b00; end
            IT: begin ifc.op = 7'b0010011; imm = 2'b00; end
            JL: begin ifc.op = 7'b1101111; imm = 2'b11; end
            default: begin ifc.op = 7'b1100011; imm = 2'b10; end
        endcase
        do_fetch(imm, fst);
        case (cls)
            LW: begin
                cyc(rbit(), v(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,imm,0), "lw_adr", 0);
                for (int i = 0; i < mst; i++)
                    cyc(1'b0, v(0,1,0,0,0,2'b00,2'b00,2'b00,ADD,imm,0), "lw_read_wait", 0);
                cyc(1'b1, v(0,1,0,0,0,2'b00,2'b00,2'b00,ADD,imm,0), "lw_read", 0);
                cyc(rbit(), v(0,0,0,0,1,2'b01,2'b00,2'b00,ADD,imm,0), "lw_wb", 1);
            end
            SW: begin
                cyc(rbit(), v(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,imm,0), "sw_adr", 0);
                for (int i = 0; i < mst; i++)
                    cyc(1'b0, v(0,1,1,0,0,2'b00,2'b00,2'b00,ADD,imm,0), "sw_write_wait", 0);
                cyc(1'b1, v(0,1,1,0,0,2'b00,2'b00,2'b00,ADD,imm,0), "sw_write", 1);
            end
            RT, IT: begin
                cyc(rbit(), v(0,0,0,0,0,2'b00,2'b10,(cls == RT) ? 2'b00 : 2'b01,
                              exp_alu(cls == RT, f3, f7),imm,0), "exec", 0);
                cyc(rbit(), v(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,imm,0), "aluwb", 1);
            end
            JL: begin
                cyc(rbit(), v(1,0,0,0,0,2'b00,2'b01,2'b10,ADD,imm,0), "jal", 0);
                cyc(rbit(), v(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,imm,0), "jal_wb", 1);
            end
            default: begin
                cyc(rbit(), v(z,0,0,0,0,2'b00,2'b10,2'b00,SUB,imm,0), "beq", 1);
            end
        endcase
    endtask

    initial begin
        ifc.op        = 7'b0000011;
        ifc.funct3    = 3'b000;
        ifc.funct7b5  = 1'b0;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        m_instret = 32'd0;
        // While reset is high: FETCH decode with all enables forced low.
        cyc(1'b1, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,2'b00,0), "reset_hold", 0);
        reset = 1'b0;

        // Directed: lw no stalls, sw with two stall cycles, funct decode, beq both ways.
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 2);
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr(BQ, 3'b000, 1'b0, 1'b0, 1, 0);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);

        // Illegal opcode traps and stays put until reset.
        ifc.op = 7'b1111111;
        do_fetch(2'b00, 0);
        for (int i = 0; i < 10; i++)
            cyc(rbit(), v(0,0,0,0,0,2'b00,2'b00,2'b00,ADD,2'b00,1), "illegal", 0);
        reset = 1'b1;
        cyc(1'b1, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,2'b00,0), "illegal_reset", 0);
        reset = 1'b0;
        m_instret = 32'd0;
        cyc(1'b0, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,2'b00,0), "after_illegal", 0);
        run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0);

        // Reset while a load is waiting on memory.
        ifc.op = 7'b0000011;
        do_fetch(2'b00, 0);
        cyc(1'b1, v(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,2'b00,0), "lwr_adr", 0);
        cyc(1'b0, v(0,1,0,0,0,2'b00,2'b00,2'b00,ADD,2'b00,0), "lwr_read_wait", 0);
        reset = 1'b1;
        cyc(1'b0, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,2'b00,0), "lwr_reset", 0);
        reset = 1'b0;
        m_instret = 32'd0;
        cyc(1'b0, v(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,2'b00,0), "lwr_after", 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), rbit(), rbit(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 op  in  7  instruction[6:0] from instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7b5  in  1  instruction[30].
REQ-007 zero  in  1  ALU zero flag from datapath.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 PCWrite  out  1  PC register enable.
REQ-010 AdrSrc  out  1  memory address select: 0 PC, 1 Result.
REQ-011 MemWrite  out  1  data memory write enable.
REQ-012 IRWrite  out  1  instruction register and OldPC enable.
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-015 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register.
REQ-016 ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
REQ-017 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; pure decode of op in every state.
REQ-019 illegal  out  1  unsupported opcode trapped.
REQ-020 instret  out  32  retired-instruction count.

Function
REQ-021 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, ILLEGAL; Moore outputs except PCWrite.
REQ-022 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready=1, then DECODE.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, add; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BEQ, other->ILLEGAL.
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op 0000011->MEMREAD, else MEMWRITE.
REQ-025 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then MEMWB.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1; ->FETCH.
REQ-027 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle in state; ->FETCH when mem_ready=1.
REQ-028 EXECR: ALUSrcA=10, ALUSrcB=00, funct decode; EXECI: ALUSrcA=10, ALUSrcB=01, funct decode; both ->ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; ->FETCH.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; ->ALUWB.
REQ-031 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero; ->FETCH.
REQ-032 Funct decode: funct3 000 -> sub if op[5]&funct7b5 else add; 010 slt; 110 or; 111 and; other funct3 -> add.
REQ-033 ILLEGAL: illegal=1, all enables 0; absorbing until reset.
REQ-034 Enables not named for a state are 0; mux selects not named are 00.
REQ-035 instret increments by 1, modulo 2^32, on the edge leaving MEMWB, MEMWRITE (mem_ready=1), ALUWB, BEQ.
REQ-036 Cycle counts with mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.

Reset
REQ-037 Reset high at an edge: state=FETCH, instret=0, illegal=0, regardless of current state or pending memory access.
REQ-038 While reset high: PCWrite, IRWrite, RegWrite, MemWrite forced 0; other outputs follow FETCH decode.
REQ-039 First cycle after reset deasserts: FETCH outputs.

Verification
REQ-040 Reset, lw (op 0000011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; instret=1.
REQ-041 sw, mem_ready low 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; instret increments once.
REQ-042 R-type funct3=000, funct7b5=1 -> ALUControl=001 in EXECR; funct7b5=0 -> 000; I-type funct3=000, funct7b5=1 -> 000.
REQ-043 beq with zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; both retire in 3 cycles.
REQ-044 op=1111111 -> ILLEGAL, illegal=1, enables 0 for 10 cycles; reset -> FETCH, illegal=0.
REQ-045 Reset asserted in MEMREAD with mem_ready=0 -> FETCH next cycle, instret=0, no RegWrite pulse.
